// File: rtl/sat_accum16.sv
// Packet accumulator around an external 16-bit RCA: feeds it (acc, sample), registers the
// optionally saturated sum, and presents one total per packet with sticky overflow and count.
module sat_accum16 #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CNT_W    = 8,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {ST_ACC, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] next_val;

  assign add_a = acc_q;
  assign add_b = in_data;

  // Clamp direction follows the sample sign: overflow is only possible when both
  // operands share a sign, so the sample sign is the true result sign.
  always_comb begin
    next_val = add_sum;
    if (add_ovf && SATURATE) begin
      next_val = in_data[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            acc_d = next_val;
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            ovf_d = ovf_q | add_ovf;
            if (in_last) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_sat_accum16.sv
// Directed bench for sat_accum16: saturating and wrapping instances share stimulus,
// each closed through its own behavioural 16-bit adder.
module tb_sat_accum16;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_last, out_ready;
  logic [15:0] in_data;

  logic        s_in_ready, s_out_valid, s_out_ovf, s_add_ovf;
  logic [15:0] s_add_a, s_add_b, s_add_sum, s_out_data;
  logic [7:0]  s_out_count;

  logic        w_in_ready, w_out_valid, w_out_ovf, w_add_ovf;
  logic [15:0] w_add_a, w_add_b, w_add_sum, w_out_data;
  logic [7:0]  w_out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign s_add_sum = s_add_a + s_add_b;
  assign s_add_ovf = (s_add_a[15] == s_add_b[15]) && (s_add_sum[15] != s_add_a[15]);
  assign w_add_sum = w_add_a + w_add_b;
  assign w_add_ovf = (w_add_a[15] == w_add_b[15]) && (w_add_sum[15] != w_add_a[15]);

  sat_accum16 #(.WIDTH(16), .CNT_W(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(s_add_a), .add_b(s_add_b), .add_sum(s_add_sum), .add_ovf(s_add_ovf),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_ovf(s_out_ovf), .out_count(s_out_count)
  );

  sat_accum16 #(.WIDTH(16), .CNT_W(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(w_add_a), .add_b(w_add_b), .add_sum(w_add_sum), .add_ovf(w_add_ovf),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_data(w_out_data), .out_ovf(w_out_ovf), .out_count(w_out_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(s_out_valid), 32'd0);
    chk("rst_out_data",  32'(s_out_data),  32'h0);
    chk("rst_out_count", 32'(s_out_count), 32'd0);
    chk("rst_out_ovf",   32'(s_out_ovf),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  32'(s_in_ready),  32'd1);

    // 1: async reset mid-packet
    send(16'h1234, 1'b0);
    send(16'h1111, 1'b0);
    chk("t1_partial_count", 32'(s_out_count), 32'd2);
    rst = 1'b1;
    #1;
    chk("t1_async_count", 32'(s_out_count), 32'd0);
    chk("t1_async_data",  32'(s_out_data),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_out_valid", 32'(s_out_valid), 32'd0);
    chk("t1_in_ready",  32'(s_in_ready),  32'd1);
    send(16'h0005, 1'b1);
    chk("t1_valid", 32'(s_out_valid), 32'd1);
    chk("t1_data",  32'(s_out_data),  32'h0005);
    chk("t1_count", 32'(s_out_count), 32'd1);
    handshake();
    chk("t1_after_hs_valid", 32'(s_out_valid), 32'd0);

    // 2: plain sum
    send(16'h0001, 1'b0);
    chk("t2_no_early_valid", 32'(s_out_valid), 32'd0);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b1);
    chk("t2_data",  32'(s_out_data),  32'h0006);
    chk("t2_ovf",   32'(s_out_ovf),   32'd0);
    chk("t2_count", 32'(s_out_count), 32'd3);
    handshake();

    // 3: positive overflow
    send(16'h7000, 1'b0);
    send(16'h2000, 1'b1);
    chk("t3_sat_data",  32'(s_out_data), 32'h7FFF);
    chk("t3_sat_ovf",   32'(s_out_ovf),  32'd1);
    chk("t3_wrap_data", 32'(w_out_data), 32'h9000);
    chk("t3_wrap_ovf",  32'(w_out_ovf),  32'd1);
    handshake();

    // 4: negative overflow, sticky flag
    send(16'h8000, 1'b0);
    chk("t4_first_ovf", 32'(s_out_ovf), 32'd0);
    send(16'hFFFF, 1'b0);
    send(16'h0001, 1'b1);
    chk("t4_sat_data",  32'(s_out_data),  32'h8001);
    chk("t4_sat_ovf",   32'(s_out_ovf),   32'd1);
    chk("t4_wrap_data", 32'(w_out_data),  32'h8000);
    chk("t4_count",     32'(s_out_count), 32'd3);
    handshake();
    chk("t4_ovf_cleared", 32'(s_out_ovf), 32'd0);

    // 5: backpressure; samples offered during DONE must be ignored
    send(16'h0009, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t5_hold_data",  32'(s_out_data),  32'h0009);
      chk("t5_hold_valid", 32'(s_out_valid), 32'd1);
      chk("t5_in_ready",   32'(s_in_ready),  32'd0);
    end
    in_valid = 1'b0;
    chk("t5_hold_count", 32'(s_out_count), 32'd1);
    handshake();
    chk("t5_ready_again", 32'(s_in_ready), 32'd1);
    send(16'h0002, 1'b1);
    chk("t5_next_data", 32'(s_out_data), 32'h0002);
    handshake();

    // 6: clr drops in-flight sample; counter saturation
    send(16'h0010, 1'b0);
    send(16'h0020, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'h0040;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    chk("t6_clr_count", 32'(s_out_count), 32'd0);
    chk("t6_clr_data",  32'(s_out_data),  32'h0);
    chk("t6_clr_ready", 32'(s_in_ready),  32'd1);
    for (int i = 0; i < 300; i++) send(16'h0000, 1'b0);
    send(16'h0000, 1'b1);
    chk("t6_sat_count", 32'(s_out_count), 32'd255);
    chk("t6_sat_data",  32'(s_out_data),  32'h0);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("t6_clr_done_valid", 32'(s_out_valid), 32'd0);
    chk("t6_clr_done_count", 32'(s_out_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
